// File: rtl/blockram_param.sv
// blockram_param: simple dual-port byte-lane RAM with clear sweep, write-first forwarding and optional output register
module blockram_param #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 256,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int SUB_W = $clog2(DATA_WIDTH/8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cfg_wr_width,
  input  logic [1:0]            cfg_rd_width,
  input  logic                  cfg_out_reg,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [SUB_W-1:0]      wr_sub,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [SUB_W-1:0]      rd_sub,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy
);
  localparam int NB = DATA_WIDTH/8;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] cnt, m_addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic clearing, wr_acc, rd_acc, v1, v2, out_fire;
  logic [NB-1:0] wmask, m_mask;
  logic [DATA_WIDTH-1:0] wdata, m_data, fwd, word_q, mux, pipe_q;
  logic [SUB_W-1:0] sub_q;
  logic [1:0] width_q;
  assign busy = rst | (state == CLEAR);
  assign clearing = ~rst & (state == CLEAR);
  assign wr_acc = wr_en & ~busy;
  assign rd_acc = rd_en & ~busy;
  assign out_fire = cfg_out_reg ? v2 : v1;
  // sweep ends once the last word has been zeroed
  always_comb begin
    state_n = state;
    state_n = (state == CLEAR && cnt == ADDR_WIDTH'(DEPTH-1)) ? RUN : state;
  end
  // state register and clear counter; reset restarts the sweep from word 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? CLEAR : RUN;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= clearing ? cnt + 1'b1 : cnt;
    end
  end
  // lane mask, replicated write data, sweep override and write-first read word
  always_comb begin
    wmask = '0;
    wdata = cfg_wr_width == 2'd2 ? {NB{wr_data[7:0]}} :
            cfg_wr_width == 2'd1 ? {(NB/2){wr_data[15:0]}} : wr_data;
    for (int i = 0; i < NB; i++)
      wmask[i] = cfg_wr_width == 2'd2 ? SUB_W'(i) == wr_sub :
                 cfg_wr_width == 2'd1 ? SUB_W'(i >> 1) == (wr_sub >> 1) : 1'b1;
    m_addr = clearing ? cnt : wr_addr;
    m_mask = clearing ? '1 : wmask;
    m_data = clearing ? '0 : wdata;
    fwd = mem[rd_addr];
    for (int i = 0; i < NB; i++)
      if (wr_acc && wr_addr == rd_addr && wmask[i]) fwd[8*i +: 8] = wdata[8*i +: 8];
    mux = width_q == 2'd2 ? DATA_WIDTH'(8'(word_q >> {sub_q, 3'b0})) :
          width_q == 2'd1 ? DATA_WIDTH'(16'(word_q >> {sub_q >> 1, 4'b0})) : word_q;
  end
  // byte-enabled array write, shared by user writes and the clear sweep
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if ((clearing || wr_acc) && m_mask[i]) mem[m_addr][8*i +: 8] <= m_data[8*i +: 8];
  end
  // read pipeline: capture, lane select, optional output register
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      word_q <= '0;
      sub_q <= '0;
      width_q <= '0;
      pipe_q <= '0;
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      v1 <= rd_acc;
      v2 <= v1;
      if (rd_acc) begin
        word_q <= fwd;
        sub_q <= rd_sub;
        width_q <= cfg_rd_width;
      end
      if (v1) pipe_q <= mux;
      rd_valid <= out_fire;
      if (out_fire) rd_data <= cfg_out_reg ? pipe_q : mux;
    end
  end
endmodule

// File: tb/tb_blockram_param.sv
// tb_blockram_param: directed self-checking bench for blockram_param (DEPTH=16, 32-bit)
module tb_blockram_param;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] cfg_wr_width, cfg_rd_width;
  logic cfg_out_reg, wr_en, rd_en, rd_valid, busy;
  logic [3:0] wr_addr, rd_addr;
  logic [1:0] wr_sub, rd_sub;
  logic [31:0] wr_data, rd_data;
  int tests = 0;
  int fails = 0;

  blockram_param #(.DATA_WIDTH(32), .DEPTH(16), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .cfg_wr_width(cfg_wr_width), .cfg_rd_width(cfg_rd_width),
    .cfg_out_reg(cfg_out_reg), .wr_en(wr_en), .wr_addr(wr_addr), .wr_sub(wr_sub),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_sub(rd_sub),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_op(input logic [3:0] a, input logic [1:0] s, input logic [1:0] w, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_sub = s; cfg_wr_width = w; wr_data = d;
    tick;
    wr_en = 1'b0;
  endtask

  task automatic rd_op(input logic [3:0] a, input logic [1:0] s, input logic [1:0] w,
                       output logic early, output logic v, output logic [31:0] d);
    rd_en = 1'b1; rd_addr = a; rd_sub = s; cfg_rd_width = w;
    tick;
    rd_en = 1'b0;
    early = rd_valid;
    tick;
    v = rd_valid;
    d = rd_data;
  endtask

  task automatic test_reset;
    logic e, v;
    logic [31:0] d;
    int nrst, n, vbad;
    for (int i = 0; i < 16; i++) wr_op(4'(i), 2'd0, 2'd0, 32'hA5A50000 | i);
    rd_op(4'd3, 2'd0, 2'd0, e, v, d);
    tests++;
    if (d !== 32'hA5A50003) begin fails++; $display("FAIL preload: got %h expected %h", d, 32'hA5A50003); end
    rst = 1'b1; rd_en = 1'b1; rd_addr = 4'd0; cfg_rd_width = 2'd0;
    nrst = 0;
    repeat (2) begin
      #1;
      if (busy === 1'b1) nrst++;
      @(posedge clk);
      #1;
    end
    tests++;
    if (rd_data !== 32'h0) begin fails++; $display("FAIL reset_rd_data: got %h expected 00000000", rd_data); end
    tests++;
    if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    rst = 1'b0;
    n = 0; vbad = 0;
    while (n < 40) begin
      #1;
      if (busy !== 1'b1) break;
      if (rd_valid !== 1'b0) vbad++;
      n++;
      @(posedge clk);
      #1;
    end
    rd_en = 1'b0;
    tests++;
    if (nrst + n !== 18) begin fails++; $display("FAIL busy_len: got %0d cycles expected 18", nrst + n); end
    tests++;
    if (vbad !== 0) begin fails++; $display("FAIL valid_in_busy: got %0d pulses expected 0", vbad); end
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      rd_op(4'(i), 2'd0, 2'd0, e, v, d);
      tests++;
      if (v !== 1'b1 || d !== 32'h0) begin
        fails++; $display("FAIL clear_word%0d: got valid=%b data=%h expected valid=1 data=00000000", i, v, d);
      end
    end
  endtask

  task automatic test_byte_lanes;
    logic e, v;
    logic [31:0] d;
    wr_op(4'd5, 2'd0, 2'd2, 32'h000000AA);
    wr_op(4'd5, 2'd1, 2'd2, 32'h000000BB);
    wr_op(4'd5, 2'd2, 2'd2, 32'h000000CC);
    wr_op(4'd5, 2'd3, 2'd2, 32'h000000DD);
    rd_op(4'd5, 2'd0, 2'd0, e, v, d);
    tests++;
    if (e !== 1'b0) begin fails++; $display("FAIL lat_early: got valid=%b expected 0", e); end
    tests++;
    if (v !== 1'b1 || d !== 32'hDDCCBBAA) begin
      fails++; $display("FAIL byte_lanes: got valid=%b data=%h expected valid=1 data=ddccbbaa", v, d);
    end
    tick;
    tests++;
    if (rd_valid !== 1'b0 || rd_data !== 32'hDDCCBBAA) begin
      fails++; $display("FAIL hold: got valid=%b data=%h expected valid=0 data=ddccbbaa", rd_valid, rd_data);
    end
    wr_op(4'd9, 2'd2, 2'd1, 32'h1234BEEF);
    wr_op(4'd9, 2'd0, 2'd1, 32'h00001234);
    rd_op(4'd9, 2'd0, 2'd0, e, v, d);
    tests++;
    if (d !== 32'hBEEF1234) begin fails++; $display("FAIL half_write: got %h expected beef1234", d); end
    wr_op(4'd10, 2'd1, 2'd3, 32'hCAFEF00D);
    rd_op(4'd10, 2'd2, 2'd3, e, v, d);
    tests++;
    if (d !== 32'hCAFEF00D) begin fails++; $display("FAIL width3_full: got %h expected cafef00d", d); end
  endtask

  task automatic test_subword_read;
    logic e, v;
    logic [31:0] d;
    rd_op(4'd5, 2'd2, 2'd1, e, v, d);
    tests++;
    if (d !== 32'h0000DDCC) begin fails++; $display("FAIL half_read_hi: got %h expected 0000ddcc", d); end
    rd_op(4'd5, 2'd1, 2'd1, e, v, d);
    tests++;
    if (d !== 32'h0000BBAA) begin fails++; $display("FAIL half_read_lo: got %h expected 0000bbaa", d); end
    rd_op(4'd5, 2'd3, 2'd2, e, v, d);
    tests++;
    if (d !== 32'h000000DD) begin fails++; $display("FAIL byte_read3: got %h expected 000000dd", d); end
    rd_op(4'd5, 2'd1, 2'd2, e, v, d);
    tests++;
    if (d !== 32'h000000BB) begin fails++; $display("FAIL byte_read1: got %h expected 000000bb", d); end
  endtask

  task automatic test_forward;
    logic e, v;
    logic [31:0] d;
    wr_op(4'd7, 2'd0, 2'd0, 32'h11223344);
    wr_en = 1'b1; wr_addr = 4'd7; wr_sub = 2'd1; cfg_wr_width = 2'd2; wr_data = 32'h000000EE;
    rd_en = 1'b1; rd_addr = 4'd7; rd_sub = 2'd0; cfg_rd_width = 2'd0;
    tick;
    wr_en = 1'b0; rd_en = 1'b0;
    tick;
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h1122EE44) begin
      fails++; $display("FAIL fwd_byte: got valid=%b data=%h expected valid=1 data=1122ee44", rd_valid, rd_data);
    end
    wr_en = 1'b1; wr_addr = 4'd7; wr_sub = 2'd2; cfg_wr_width = 2'd1; wr_data = 32'h00005566;
    rd_en = 1'b1; rd_addr = 4'd7; rd_sub = 2'd3; cfg_rd_width = 2'd2;
    tick;
    wr_en = 1'b0; rd_en = 1'b0;
    tick;
    tests++;
    if (rd_data !== 32'h00000055) begin fails++; $display("FAIL fwd_half_byte3: got %h expected 00000055", rd_data); end
    rd_op(4'd7, 2'd0, 2'd0, e, v, d);
    tests++;
    if (d !== 32'h5566EE44) begin fails++; $display("FAIL fwd_stored: got %h expected 5566ee44", d); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] tbl [3];
    logic exp_v;
    tbl[0] = 32'h01010101; tbl[1] = 32'h20202020; tbl[2] = 32'h3C3C3C3C;
    for (int i = 0; i < 3; i++) wr_op(4'(i + 1), 2'd0, 2'd0, tbl[i]);
    for (int lat = 2; lat >= 1; lat--) begin
      cfg_out_reg = (lat == 2);
      for (int k = 0; k < 6; k++) begin
        rd_en = (k < 3); rd_addr = 4'(k + 1); rd_sub = 2'd0; cfg_rd_width = 2'd0;
        tick;
        exp_v = (k >= lat) && (k < lat + 3);
        tests++;
        if (rd_valid !== exp_v || (exp_v && rd_data !== tbl[k - lat])) begin
          fails++;
          $display("FAIL b2b_lat%0d_k%0d: got valid=%b data=%h expected valid=%b data=%h",
                   lat, k, rd_valid, rd_data, exp_v, exp_v ? tbl[k - lat] : rd_data);
        end
      end
    end
    cfg_out_reg = 1'b0;
  endtask

  task automatic test_mid_sweep;
    logic e, v;
    logic [31:0] d;
    int n;
    wr_op(4'd12, 2'd0, 2'd0, 32'h0BADF00D);
    wr_op(4'd15, 2'd0, 2'd0, 32'h12345678);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    repeat (9) tick;
    rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b expected 1", busy); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    while (n < 40) begin
      #1;
      if (busy !== 1'b1) break;
      n++;
      @(posedge clk);
      #1;
    end
    tests++;
    if (n !== 16) begin fails++; $display("FAIL mid_busy_len: got %0d cycles expected 16", n); end
    @(posedge clk);
    #1;
    rd_op(4'd12, 2'd0, 2'd0, e, v, d);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL mid_clear12: got %h expected 00000000", d); end
    rd_op(4'd15, 2'd0, 2'd0, e, v, d);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL mid_clear15: got %h expected 00000000", d); end
  endtask

  initial begin
    rst = 1'b1; cfg_wr_width = 2'd0; cfg_rd_width = 2'd0; cfg_out_reg = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_sub = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; rd_sub = '0;
    tick;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 40 && busy !== 1'b0; i++) tick;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL bringup: busy got %b expected 0", busy); end
    test_reset;
    test_byte_lanes;
    test_subword_read;
    test_forward;
    test_back_to_back;
    test_mid_sweep;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
